// File: rtl/traffic_phase_ctrl.sv
// NS/EW phase sequencer with 1 s countdown and shift-add-3 BCD display converter.
// Define TRAFFIC_ALLRED_EN to insert all-red clearance phases AR1/AR2.
module traffic_phase_ctrl #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int NS_GREEN_S = 30,
    parameter int EW_GREEN_S = 20,
    parameter int YELLOW_S   = 3,
    parameter int ALLRED_S   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [7:0] remain,
    output logic [7:0] bcd_out,
    output logic       bcd_valid
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [7:0] D_NSG = 8'(NS_GREEN_S);
    localparam logic [7:0] D_EWG = 8'(EW_GREEN_S);
    localparam logic [7:0] D_Y   = 8'(YELLOW_S);
`ifdef TRAFFIC_ALLRED_EN
    localparam logic [7:0] D_AR  = 8'(ALLRED_S);
`endif

    if (TICK_DIV < 16) begin : g_bad_tick
        $error("TICK_DIV must be >= 16");
    end
    if (NS_GREEN_S < 1 || NS_GREEN_S > 99) begin : g_bad_nsg
        $error("NS_GREEN_S out of range 1..99");
    end
    if (EW_GREEN_S < 1 || EW_GREEN_S > 99) begin : g_bad_ewg
        $error("EW_GREEN_S out of range 1..99");
    end
    if (YELLOW_S < 1 || YELLOW_S > 99) begin : g_bad_y
        $error("YELLOW_S out of range 1..99");
    end
    if (ALLRED_S < 1 || ALLRED_S > 99) begin : g_bad_ar
        $error("ALLRED_S out of range 1..99");
    end

`ifdef TRAFFIC_ALLRED_EN
    typedef enum logic [2:0] {
        PH_NS_G, PH_NS_Y, PH_AR1, PH_EW_G, PH_EW_Y, PH_AR2
    } phase_t;
`else
    typedef enum logic [1:0] {
        PH_NS_G, PH_NS_Y, PH_EW_G, PH_EW_Y
    } phase_t;
`endif

    typedef enum logic {CV_IDLE, CV_SHIFT} cv_t;

    phase_t        r_phase;
    phase_t        w_phase_next;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_next;
    logic [7:0]    r_remain;
    logic [7:0]    w_remain_next;
    logic [2:0]    r_ns;
    logic [2:0]    r_ew;
    logic [2:0]    w_ns_next;
    logic [2:0]    w_ew_next;
    logic          w_tick;

    cv_t           r_cv_state;
    cv_t           w_cv_next;
    logic          r_start;
    logic [15:0]   r_scratch;
    logic [15:0]   w_scr_next;
    logic [15:0]   w_adj;
    logic [15:0]   w_shift;
    logic [2:0]    r_cnt;
    logic [2:0]    w_cnt_next;
    logic [7:0]    r_bcd;
    logic [7:0]    w_bcd_next;
    logic          r_valid;
    logic          w_valid_next;

    always_comb begin
        w_tick        = run && (r_presc == PRESC_MAX);
        w_presc_next  = r_presc;
        w_phase_next  = r_phase;
        w_remain_next = r_remain;
        if (run) begin
            w_presc_next = w_tick ? '0 : r_presc + PW'(1);
        end
        if (w_tick) begin
            if (r_remain > 8'd1) begin
                w_remain_next = r_remain - 8'd1;
            end else begin
                unique case (r_phase)
                    PH_NS_G: begin
                        w_phase_next  = PH_NS_Y;
                        w_remain_next = D_Y;
                    end
`ifdef TRAFFIC_ALLRED_EN
                    PH_NS_Y: begin
                        w_phase_next  = PH_AR1;
                        w_remain_next = D_AR;
                    end
                    PH_AR1: begin
                        w_phase_next  = PH_EW_G;
                        w_remain_next = D_EWG;
                    end
                    PH_EW_Y: begin
                        w_phase_next  = PH_AR2;
                        w_remain_next = D_AR;
                    end
                    PH_AR2: begin
                        w_phase_next  = PH_NS_G;
                        w_remain_next = D_NSG;
                    end
`else
                    PH_NS_Y: begin
                        w_phase_next  = PH_EW_G;
                        w_remain_next = D_EWG;
                    end
                    PH_EW_Y: begin
                        w_phase_next  = PH_NS_G;
                        w_remain_next = D_NSG;
                    end
`endif
                    PH_EW_G: begin
                        w_phase_next  = PH_EW_Y;
                        w_remain_next = D_Y;
                    end
                    default: begin
                        w_phase_next  = PH_NS_G;
                        w_remain_next = D_NSG;
                    end
                endcase
            end
        end
    end

    // Lamps decode from the next phase so they register on the phase edge.
    always_comb begin
        w_ns_next = 3'b100;
        w_ew_next = 3'b100;
        unique case (w_phase_next)
            PH_NS_G: w_ns_next = 3'b001;
            PH_NS_Y: w_ns_next = 3'b010;
            PH_EW_G: w_ew_next = 3'b001;
            PH_EW_Y: w_ew_next = 3'b010;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase  <= PH_NS_G;
            r_presc  <= '0;
            r_remain <= D_NSG;
            r_ns     <= 3'b001;
            r_ew     <= 3'b100;
        end else begin
            r_phase  <= w_phase_next;
            r_presc  <= w_presc_next;
            r_remain <= w_remain_next;
            r_ns     <= w_ns_next;
            r_ew     <= w_ew_next;
        end
    end

    always_comb begin
        w_cv_next    = r_cv_state;
        w_scr_next   = r_scratch;
        w_cnt_next   = r_cnt;
        w_bcd_next   = r_bcd;
        w_valid_next = r_valid;
        w_adj        = r_scratch;
        if (r_scratch[11:8] >= 4'd5) begin
            w_adj[11:8] = r_scratch[11:8] + 4'd3;
        end
        if (r_scratch[15:12] >= 4'd5) begin
            w_adj[15:12] = r_scratch[15:12] + 4'd3;
        end
        w_shift = {w_adj[14:0], 1'b0};
        if (r_start) begin
            w_cv_next    = CV_SHIFT;
            w_scr_next   = {8'h00, r_remain};
            w_cnt_next   = 3'd0;
            w_valid_next = 1'b0;
        end else if (r_cv_state == CV_SHIFT) begin
            w_scr_next = w_shift;
            w_cnt_next = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
                w_cv_next    = CV_IDLE;
                w_bcd_next   = w_shift[15:8];
                w_valid_next = 1'b1;
            end
        end
    end

    // r_start is the load request; reset arms it so release converts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cv_state <= CV_IDLE;
            r_start    <= 1'b1;
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_bcd      <= 8'h00;
            r_valid    <= 1'b0;
        end else begin
            r_cv_state <= w_cv_next;
            r_start    <= (w_remain_next != r_remain);
            r_scratch  <= w_scr_next;
            r_cnt      <= w_cnt_next;
            r_bcd      <= w_bcd_next;
            r_valid    <= w_valid_next;
        end
    end

    assign ns_light  = r_ns;
    assign ew_light  = r_ew;
    assign remain    = r_remain;
    assign bcd_out   = r_bcd;
    assign bcd_valid = r_valid;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed-vector bench for traffic_phase_ctrl: reset, sequencing, pause and BCD.
module tb_traffic_phase_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic       rst_d = 1'b1, run_d = 1'b0;
    logic [2:0] ns_d, ew_d;
    logic [7:0] rem_d, bcd_d;
    logic       val_d;

    logic       rst_s = 1'b1, run_s = 1'b0;
    logic [2:0] ns_s, ew_s;
    logic [7:0] rem_s, bcd_s;
    logic       val_s;

    logic       rst_b = 1'b1, run_b = 1'b0;
    logic [2:0] ns_b, ew_b;
    logic [7:0] rem_b, bcd_b;
    logic       val_b;

    traffic_phase_ctrl u_def (
        .clk(clk), .rst(rst_d), .run(run_d),
        .ns_light(ns_d), .ew_light(ew_d), .remain(rem_d),
        .bcd_out(bcd_d), .bcd_valid(val_d)
    );

    traffic_phase_ctrl #(
        .TICK_DIV(16), .NS_GREEN_S(3), .EW_GREEN_S(4),
        .YELLOW_S(2), .ALLRED_S(1)
    ) u_seq (
        .clk(clk), .rst(rst_s), .run(run_s),
        .ns_light(ns_s), .ew_light(ew_s), .remain(rem_s),
        .bcd_out(bcd_s), .bcd_valid(val_s)
    );

    traffic_phase_ctrl #(
        .TICK_DIV(16), .NS_GREEN_S(99)
    ) u_bcd (
        .clk(clk), .rst(rst_b), .run(run_b),
        .ns_light(ns_b), .ew_light(ew_b), .remain(rem_b),
        .bcd_out(bcd_b), .bcd_valid(val_b)
    );

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Default instance: reset state and release conversion.
        step(3);
        chk("rst_ns", 16'(ns_d), 16'h1);
        chk("rst_ew", 16'(ew_d), 16'h4);
        chk("rst_remain", 16'(rem_d), 16'd30);
        chk("rst_valid", 16'(val_d), 16'h0);
        chk("rst_bcd", 16'(bcd_d), 16'h00);
        rst_d = 1'b0;
        step(8);
        chk("rel_valid_e8", 16'(val_d), 16'h0);
        step(1);
        chk("rel_valid_e9", 16'(val_d), 16'h1);
        chk("rel_bcd_e9", 16'(bcd_d), 16'h30);

        // Default instance: reset lands mid-conversion.
        rst_d = 1'b1;
        step(1);
        rst_d = 1'b0;
        step(3);
        rst_d = 1'b1;
        step(1);
        chk("midrst_bcd", 16'(bcd_d), 16'h00);
        chk("midrst_valid", 16'(val_d), 16'h0);
        rst_d = 1'b0;
        step(9);
        chk("midrst_redo_bcd", 16'(bcd_d), 16'h30);
        chk("midrst_redo_valid", 16'(val_d), 16'h1);

        // Sequencer instance: countdown and phase order.
        run_s = 1'b1;
        step(1);
        rst_s = 1'b0;
        step(15);
        chk("seq_r15_rem", 16'(rem_s), 16'd3);
        step(1);
        chk("seq_t1_rem", 16'(rem_s), 16'd2);
        step(16);
        chk("seq_t2_rem", 16'(rem_s), 16'd1);
        step(15);
        chk("seq_pre_nsy_ns", 16'(ns_s), 16'h1);
        step(1);
        chk("nsy_ns", 16'(ns_s), 16'h2);
        chk("nsy_ew", 16'(ew_s), 16'h4);
        chk("nsy_rem", 16'(rem_s), 16'd2);
        step(16);
        chk("nsy_rem1", 16'(rem_s), 16'd1);
`ifdef TRAFFIC_ALLRED_EN
        step(16);
        chk("ar1_ns", 16'(ns_s), 16'h4);
        chk("ar1_ew", 16'(ew_s), 16'h4);
        chk("ar1_rem", 16'(rem_s), 16'd1);
`endif
        step(16);
        chk("ewg_ns", 16'(ns_s), 16'h4);
        chk("ewg_ew", 16'(ew_s), 16'h1);
        chk("ewg_rem", 16'(rem_s), 16'd4);
        step(48);
        chk("ewg_rem1", 16'(rem_s), 16'd1);
        step(16);
        chk("ewy_ew", 16'(ew_s), 16'h2);
        chk("ewy_rem", 16'(rem_s), 16'd2);
        step(16);
        chk("ewy_rem1", 16'(rem_s), 16'd1);
`ifdef TRAFFIC_ALLRED_EN
        step(16);
        chk("ar2_ns", 16'(ns_s), 16'h4);
        chk("ar2_ew", 16'(ew_s), 16'h4);
        chk("ar2_rem", 16'(rem_s), 16'd1);
`endif
        step(16);
        chk("wrap_ns", 16'(ns_s), 16'h1);
        chk("wrap_ew", 16'(ew_s), 16'h4);
        chk("wrap_rem", 16'(rem_s), 16'd3);

        // Pause with remain=2 and prescaler at 5.
        step(16);
        chk("pause_pre_rem", 16'(rem_s), 16'd2);
        step(5);
        run_s = 1'b0;
        step(100);
        chk("pause_rem", 16'(rem_s), 16'd2);
        chk("pause_ns", 16'(ns_s), 16'h1);
        run_s = 1'b1;
        step(10);
        chk("resume_10_rem", 16'(rem_s), 16'd2);
        step(1);
        chk("resume_11_rem", 16'(rem_s), 16'd1);

        // BCD instance: 99 countdown.
        run_b = 1'b1;
        step(1);
        rst_b = 1'b0;
        step(9);
        chk("bcd99", 16'(bcd_b), 16'h99);
        chk("bcd99_valid", 16'(val_b), 16'h1);
        step(7);
        chk("rem98", 16'(rem_b), 16'd98);
        step(1);
        chk("e1_valid", 16'(val_b), 16'h0);
        step(4);
        chk("e5_hold", 16'(bcd_b), 16'h99);
        step(3);
        chk("e8_valid", 16'(val_b), 16'h0);
        step(1);
        chk("e9_valid", 16'(val_b), 16'h1);
        chk("bcd98", 16'(bcd_b), 16'h98);
        step(1408);
        chk("rem10", 16'(rem_b), 16'd10);
        chk("bcd10", 16'(bcd_b), 16'h10);
        step(48);
        chk("rem7", 16'(rem_b), 16'd7);
        chk("bcd07", 16'(bcd_b), 16'h07);
        step(7);
        chk("rem6", 16'(rem_b), 16'd6);
        step(3);
        rst_b = 1'b1;
        step(1);
        chk("bmid_bcd", 16'(bcd_b), 16'h00);
        chk("bmid_valid", 16'(val_b), 16'h0);
        chk("bmid_rem", 16'(rem_b), 16'd99);
        rst_b = 1'b0;
        step(9);
        chk("bmid_redo", 16'(bcd_b), 16'h99);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
